// File: rtl/serial_mag_compare.sv
// serial_mag_compare
//   Accumulates MSB-first E/G/L digit flags from a 2-bit comparator slice and
//   emits one equal/greater/less verdict per operand pair over valid/ready.
//   Optional feature macro: CMP_ONEHOT_CHECK_EN (adds res_err, one-hot flag check).
module serial_mag_compare #(
   parameter int MAX_DIGITS = 8,
   parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_e,
   input  logic             in_g,
   input  logic             in_l,
   input  logic             in_last,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_e,
   output logic             res_g,
   output logic             res_l,
   output logic             res_ovf,
   output logic [CNT_W-1:0] res_cnt
`ifdef CMP_ONEHOT_CHECK_EN
   ,
   output logic             res_err
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DIGITS);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           next_state_s;

   logic [CNT_W-1:0] cnt_r;
   logic             decided_r;
   logic             acc_g_r;
   logic             acc_l_r;

   logic             accept_s;
   logic             rearm_s;
   logic             finish_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             dig_g_s;
   logic             dig_l_s;
   logic             new_g_s;
   logic             new_l_s;
   logic             new_decided_s;

`ifdef CMP_ONEHOT_CHECK_EN
   logic             err_r;
   logic             bad_s;

   // True when exactly one of the three slice flags is set.
   function automatic logic is_onehot(input logic e, input logic g, input logic l);
      is_onehot = ({e, g, l} == 3'b100) || ({e, g, l} == 3'b010) || ({e, g, l} == 3'b001);
   endfunction
`else
   // The equal flag is implied by the absence of g/l, so it is not consumed here.
   logic             unused_in_e_s;
   assign unused_in_e_s = in_e;
`endif

   // Handshake, counter step and per-digit verdict decode.
   always_comb begin
      accept_s  = in_valid & in_ready;
      rearm_s   = (state_r == DONE) & res_valid & res_ready;
      cnt_inc_s = cnt_r;
      if (cnt_r != CNT_MAX) begin
         cnt_inc_s = cnt_r + CNT_ONE;
      end else begin
         cnt_inc_s = cnt_r;
      end
      finish_s = accept_s & (in_last | (cnt_inc_s == CNT_MAX));
`ifdef CMP_ONEHOT_CHECK_EN
      // An illegal flag pattern counts as an equal digit.
      bad_s   = ~is_onehot(in_e, in_g, in_l);
      dig_g_s = in_g & ~bad_s;
      dig_l_s = in_l & ~bad_s;
`else
      // Greater wins if the slice raises both g and l.
      dig_g_s = in_g;
      dig_l_s = in_l & ~in_g;
`endif
      // Once the first unequal digit is seen, the verdict is frozen.
      if (decided_r) begin
         new_g_s = acc_g_r;
         new_l_s = acc_l_r;
      end else begin
         new_g_s = dig_g_s;
         new_l_s = dig_l_s;
      end
      new_decided_s = decided_r | dig_g_s | dig_l_s;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (finish_s) begin
               next_state_s = DONE;
            end else if (accept_s) begin
               next_state_s = ACCUM;
            end else begin
               next_state_s = IDLE;
            end
         end
         ACCUM: begin
            if (finish_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = ACCUM;
            end
         end
         DONE: begin
            if (rearm_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = DONE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Handshake outputs are registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready  <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         in_ready  <= (next_state_s != DONE);
         res_valid <= (next_state_s == DONE);
      end
   end

   // Working accumulator: cleared on re-arm, updated per accepted digit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r     <= CNT_ZERO;
         decided_r <= 1'b0;
         acc_g_r   <= 1'b0;
         acc_l_r   <= 1'b0;
`ifdef CMP_ONEHOT_CHECK_EN
         err_r     <= 1'b0;
`endif
      end else if (rearm_s) begin
         cnt_r     <= CNT_ZERO;
         decided_r <= 1'b0;
         acc_g_r   <= 1'b0;
         acc_l_r   <= 1'b0;
`ifdef CMP_ONEHOT_CHECK_EN
         err_r     <= 1'b0;
`endif
      end else if (accept_s) begin
         cnt_r     <= cnt_inc_s;
         decided_r <= new_decided_s;
         acc_g_r   <= new_g_s;
         acc_l_r   <= new_l_s;
`ifdef CMP_ONEHOT_CHECK_EN
         err_r     <= err_r | bad_s;
`endif
      end else begin
         cnt_r     <= cnt_r;
         decided_r <= decided_r;
         acc_g_r   <= acc_g_r;
         acc_l_r   <= acc_l_r;
`ifdef CMP_ONEHOT_CHECK_EN
         err_r     <= err_r;
`endif
      end
   end

   // Verdict registers: loaded on the completing digit, otherwise held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_e   <= 1'b0;
         res_g   <= 1'b0;
         res_l   <= 1'b0;
         res_ovf <= 1'b0;
         res_cnt <= CNT_ZERO;
      end else if (finish_s) begin
         res_e   <= ~new_g_s & ~new_l_s;
         res_g   <= new_g_s;
         res_l   <= new_l_s;
         res_ovf <= ~in_last;
         res_cnt <= cnt_inc_s;
      end else begin
         res_e   <= res_e;
         res_g   <= res_g;
         res_l   <= res_l;
         res_ovf <= res_ovf;
         res_cnt <= res_cnt;
      end
   end

`ifdef CMP_ONEHOT_CHECK_EN
   // Error flag travels with the verdict and drops on re-arm.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_err <= 1'b0;
      end else if (rearm_s) begin
         res_err <= 1'b0;
      end else if (finish_s) begin
         res_err <= err_r | bad_s;
      end else begin
         res_err <= res_err;
      end
   end
`endif

endmodule

// File: tb/tb_serial_mag_compare.sv
// Self-checking bench for serial_mag_compare: directed scenarios plus random
// operand pairs checked against a numeric model of the operand prefixes.
module tb_serial_mag_compare;

   localparam int MAXD = 8;
   localparam int CW   = $clog2(MAXD + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_e = 1'b0;
   logic          in_g = 1'b0;
   logic          in_l = 1'b0;
   logic          in_last = 1'b0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic          res_e;
   logic          res_g;
   logic          res_l;
   logic          res_ovf;
   logic [CW-1:0] res_cnt;
`ifdef CMP_ONEHOT_CHECK_EN
   logic          res_err;
`endif

   int total  = 0;
   int passed = 0;

   int ga [16];
   int gb [16];
   logic exp_e, exp_g, exp_l, exp_ovf;
   int   exp_cnt;

   serial_mag_compare #(.MAX_DIGITS(MAXD)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_e      (in_e),
      .in_g      (in_g),
      .in_l      (in_l),
      .in_last   (in_last),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_e     (res_e),
      .res_g     (res_g),
      .res_l     (res_l),
      .res_ovf   (res_ovf),
      .res_cnt   (res_cnt)
`ifdef CMP_ONEHOT_CHECK_EN
      ,
      .res_err   (res_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total = total + 1;
      assert (obs === expv) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Model: verdict is the numeric comparison of the received digit prefixes.
   task automatic compute_expect(input int n);
      longint av;
      longint bv;
      int k;
      k  = (n > MAXD) ? MAXD : n;
      av = 0;
      bv = 0;
      for (int i = 0; i < k; i++) begin
         av = av * 4 + ga[i];
         bv = bv * 4 + gb[i];
      end
      exp_e   = (av == bv);
      exp_g   = (av > bv);
      exp_l   = (av < bv);
      exp_ovf = (n > MAXD);
      exp_cnt = k;
   endtask

   // Present one digit and wait (bounded) until it is accepted.
   task automatic send_digit(input logic e, input logic g, input logic l, input logic last);
      int guard;
      guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_e = e;
      in_g = g;
      in_l = l;
      in_last = last;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("accept_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   // Stream the digit pairs in ga/gb (n digits, stops early at MAXD) and check the verdict.
   task automatic run_compare(input int n, input string tag);
      int k;
      k = (n > MAXD) ? MAXD : n;
      compute_expect(n);
      for (int i = 0; i < k; i++) begin
         send_digit(ga[i] == gb[i], ga[i] > gb[i], ga[i] < gb[i], i == n - 1);
         if (i < k - 1) check({tag, "_early_valid"}, {31'd0, res_valid}, 32'd0);
      end
      check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
      check({tag, "_e"},     {31'd0, res_e},     {31'd0, exp_e});
      check({tag, "_g"},     {31'd0, res_g},     {31'd0, exp_g});
      check({tag, "_l"},     {31'd0, res_l},     {31'd0, exp_l});
      check({tag, "_ovf"},   {31'd0, res_ovf},   {31'd0, exp_ovf});
      check({tag, "_cnt"},   32'(res_cnt),       32'(exp_cnt));
      check({tag, "_inrdy"}, {31'd0, in_ready},  32'd0);
   endtask

   // Take the verdict after some stall cycles and check re-arm behaviour.
   task automatic consume(input int stall, input string tag);
      repeat (stall) @(negedge clk);
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check({tag, "_rearm_valid"}, {31'd0, res_valid}, 32'd0);
      check({tag, "_rearm_inrdy"}, {31'd0, in_ready},  32'd1);
      check({tag, "_keep_cnt"},    32'(res_cnt),       32'(exp_cnt));
      check({tag, "_keep_g"},      {31'd0, res_g},     {31'd0, exp_g});
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, res_valid}, 32'd0);
      check("rst_inrdy", {31'd0, in_ready},  32'd0);
      check("rst_cnt",   32'(res_cnt),       32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_inrdy", {31'd0, in_ready}, 32'd1);

      // A=0xB4, B=0xB4: all equal
      ga[0] = 2; ga[1] = 3; ga[2] = 1; ga[3] = 0;
      gb[0] = 2; gb[1] = 3; gb[2] = 1; gb[3] = 0;
      run_compare(4, "eq4");
      consume(0, "eq4");

      // G,L,L,L: first digit decides
      ga[0] = 3; ga[1] = 0; ga[2] = 0; ga[3] = 0;
      gb[0] = 2; gb[1] = 1; gb[2] = 1; gb[3] = 1;
      run_compare(4, "glll");
      consume(1, "glll");

      // E,E,L then E... with no last: overflow at MAXD
      for (int i = 0; i < 9; i++) begin
         ga[i] = 1;
         gb[i] = 1;
      end
      gb[2] = 2;
      run_compare(9, "ovf");

      // Verdict held under back-pressure; offered digits are ignored
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_last = 1'b1;
         in_g = 1'b1;
         check("stall_valid", {31'd0, res_valid}, 32'd1);
         check("stall_inrdy", {31'd0, in_ready},  32'd0);
         check("stall_l",     {31'd0, res_l},     {31'd0, exp_l});
         check("stall_ovf",   {31'd0, res_ovf},   {31'd0, exp_ovf});
         check("stall_cnt",   32'(res_cnt),       32'(exp_cnt));
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last = 1'b0;
      in_g = 1'b0;
      consume(0, "ovf");

      // Asynchronous reset in the middle of a compare
      send_digit(1'b1, 1'b0, 1'b0, 1'b0);
      send_digit(1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_l",     {31'd0, res_l},     32'd0);
      check("arst_ovf",   {31'd0, res_ovf},   32'd0);
      check("arst_cnt",   32'(res_cnt),       32'd0);
      check("arst_valid", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      ga[0] = 1; ga[1] = 3;
      gb[0] = 1; gb[1] = 2;
      run_compare(2, "after_rst");
      consume(0, "after_rst");

      // Random operand pairs against the model
      for (int t = 0; t < 25; t++) begin
         int n;
         n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++) begin
            ga[i] = $urandom_range(0, 3);
            gb[i] = ($urandom_range(0, 2) != 0) ? ga[i] : $urandom_range(0, 3);
         end
         run_compare(n, "rnd");
         consume($urandom_range(0, 3), "rnd");
      end

`ifdef CMP_ONEHOT_CHECK_EN
      // Illegal flag pattern is flagged and treated as equal
      send_digit(1'b0, 1'b1, 1'b1, 1'b0);
      send_digit(1'b1, 1'b0, 1'b0, 1'b1);
      exp_e = 1'b1; exp_g = 1'b0; exp_l = 1'b0; exp_cnt = 2;
      check("err_flag", {31'd0, res_err}, 32'd1);
      check("err_e",    {31'd0, res_e},   32'd1);
      check("err_g",    {31'd0, res_g},   32'd0);
      check("err_cnt",  32'(res_cnt),     32'd2);
      consume(0, "err");
      check("err_rearm", {31'd0, res_err}, 32'd0);
      ga[0] = 0; gb[0] = 3;
      run_compare(1, "err_clean");
      check("err_clean_flag", {31'd0, res_err}, 32'd0);
      consume(0, "err_clean");
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
